// File: rtl/key_schedule_seq.sv
// Sequential AES-128 key schedule: one keyExpansion step per clock, all round
// keys kept in a small register file behind a registered read port.
module key_schedule_seq #(
  parameter int NROUNDS = 10,
  parameter int IDXW    = 4
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            start,
  input  logic [127:0]    keyIn,
  output logic            busy,
  output logic            keyReady,
  input  logic [IDXW-1:0] rdIdx,
  input  logic            rdEn,
  output logic [127:0]    rdKey,
  output logic            rdValid
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] EXPAND = 1'b1;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NROUNDS);
  localparam logic [IDXW-1:0] ONE      = IDXW'(1);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box computed as x^254 in GF(2^8) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] num);
    case (num)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Column 0 is the most significant word of the key.
  function automatic logic [127:0] key_expansion(input logic [127:0] prev, input logic [3:0] num);
    logic [31:0] rot;
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;
    rot = {prev[23:0], prev[31:24]};
    t   = {sbox(rot[31:24]) ^ rcon(num), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    n0  = prev[127:96] ^ t;
    n1  = prev[95:64]  ^ n0;
    n2  = prev[63:32]  ^ n1;
    n3  = prev[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  logic [127:0]    key_mem [0:NROUNDS];

  logic [0:0]      state_q, state_d;
  logic [IDXW-1:0] cnt_q, cnt_d;
  logic [IDXW-1:0] gen_q, gen_d;
  logic            busy_q, busy_d;
  logic            key_ready_q, key_ready_d;
  logic [127:0]    last_key_q, last_key_d;
  logic [127:0]    rd_key_q, rd_key_d;
  logic            rd_valid_q, rd_valid_d;

  logic            wr_en;
  logic [IDXW-1:0] wr_idx;
  logic [127:0]    wr_data;
  logic [127:0]    next_key;
  logic            rd_in_range, rd_generated, rd_being_written;

  // The only expansion stage; it chains from the most recently written key.
  assign next_key = key_expansion(last_key_q, cnt_q[3:0]);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gen_d       = gen_q;
    busy_d      = busy_q;
    key_ready_d = key_ready_q;
    last_key_d  = last_key_q;
    wr_en       = 1'b0;
    wr_idx      = cnt_q;
    wr_data     = next_key;
    case (state_q)
      IDLE: begin
        if (start) begin
          wr_en       = 1'b1;
          wr_idx      = '0;
          wr_data     = keyIn;
          last_key_d  = keyIn;
          gen_d       = ONE;
          cnt_d       = ONE;
          busy_d      = 1'b1;
          key_ready_d = 1'b0;
          state_d     = EXPAND;
        end
      end
      EXPAND: begin
        wr_en      = 1'b1;
        last_key_d = next_key;
        gen_d      = gen_q + ONE;
        cnt_d      = cnt_q + ONE;
        if (cnt_q == LAST_IDX) begin
          busy_d      = 1'b0;
          key_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A slot being written this edge returns its old content but is never valid.
  always_comb begin
    rd_in_range      = (rdIdx <= LAST_IDX);
    rd_generated     = (rdIdx < gen_q);
    rd_being_written = (state_q == EXPAND) && (rdIdx == cnt_q);
    rd_key_d         = rd_key_q;
    rd_valid_d       = rd_valid_q;
    if (rdEn) begin
      rd_valid_d = rd_in_range && rd_generated;
      rd_key_d   = (rd_in_range && (rd_generated || rd_being_written)) ? key_mem[rdIdx] : 128'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) key_mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gen_q       <= '0;
      busy_q      <= 1'b0;
      key_ready_q <= 1'b0;
      last_key_q  <= 128'h0;
      rd_key_q    <= 128'h0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gen_q       <= gen_d;
      busy_q      <= busy_d;
      key_ready_q <= key_ready_d;
      last_key_q  <= last_key_d;
      rd_key_q    <= rd_key_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign busy     = busy_q;
  assign keyReady = key_ready_q;
  assign rdKey    = rd_key_q;
  assign rdValid  = rd_valid_q;

endmodule

// File: tb/tb_key_schedule_seq.sv
// Bench for key_schedule_seq: FIPS-197 and all-zero key schedules, read-port
// timing during expansion, ignored starts, restart and asynchronous reset.
module tb_key_schedule_seq;

  logic         clk = 1'b0;
  logic         rstN;
  logic         start;
  logic [127:0] keyIn;
  logic         busy;
  logic         keyReady;
  logic [3:0]   rdIdx;
  logic         rdEn;
  logic [127:0] rdKey;
  logic         rdValid;

  always #5 clk = ~clk;

  key_schedule_seq #(.NROUNDS(10), .IDXW(4)) dut (
    .clk(clk), .rstN(rstN), .start(start), .keyIn(keyIn),
    .busy(busy), .keyReady(keyReady),
    .rdIdx(rdIdx), .rdEn(rdEn), .rdKey(rdKey), .rdValid(rdValid)
  );

  typedef struct {
    logic [3:0]   idx;
    logic         exp_v;
    logic         chk_key;
    logic [127:0] exp_k;
  } rd_rec_t;

  rd_rec_t      sb[$];
  rd_rec_t      tbl [0:12];
  logic [127:0] fips [0:10];
  logic [127:0] zk1, zk10, kfips;
  int           n_vec = 0;
  int           n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1ns after the rising edge.
  task automatic cyc(input logic do_start, input logic [127:0] k, input logic do_rd,
                     input logic [3:0] idx, input logic ev, input logic ck, input logic [127:0] ek);
    rd_rec_t r;
    @(negedge clk);
    start = do_start;
    keyIn = k;
    rdEn  = do_rd;
    rdIdx = idx;
    if (do_rd) begin
      r.idx = idx; r.exp_v = ev; r.chk_key = ck; r.exp_k = ek;
      sb.push_back(r);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    rdEn  = 1'b0;
    if (do_rd) begin
      r = sb.pop_front();
      chk($sformatf("rdValid idx%0d", r.idx), {127'h0, rdValid}, {127'h0, r.exp_v});
      if (r.chk_key) chk($sformatf("rdKey idx%0d", r.idx), rdKey, r.exp_k);
    end
  endtask

  task automatic status(input string nm, input logic eb, input logic er);
    chk({nm, " busy"}, {127'h0, busy}, {127'h0, eb});
    chk({nm, " keyReady"}, {127'h0, keyReady}, {127'h0, er});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    kfips    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips[0]  = kfips;
    fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    zk1      = 128'h62636363626363636263636362636363;
    zk10     = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    for (int i = 0; i <= 10; i++) begin
      tbl[i].idx = 4'(i); tbl[i].exp_v = 1'b1; tbl[i].chk_key = 1'b1; tbl[i].exp_k = fips[i];
    end
    tbl[11].idx = 4'd11; tbl[11].exp_v = 1'b0; tbl[11].chk_key = 1'b1; tbl[11].exp_k = 128'h0;
    tbl[12].idx = 4'd15; tbl[12].exp_v = 1'b0; tbl[12].chk_key = 1'b1; tbl[12].exp_k = 128'h0;

    rstN = 1'b0; start = 1'b0; keyIn = '0; rdEn = 1'b0; rdIdx = '0;
    repeat (2) @(posedge clk);
    #1;
    status("reset", 1'b0, 1'b0);
    chk("reset rdKey", rdKey, 128'h0);
    chk("reset rdValid", {127'h0, rdValid}, 128'h0);
    @(negedge clk);
    rstN = 1'b1;

    // Reset in the middle of an expansion
    cyc(1'b1, kfips, 1'b0, 4'd0, 1'b0, 1'b0, 128'h0);
    cyc(1'b0, kfips, 1'b1, 4'd0, 1'b1, 1'b1, kfips);
    repeat (3) cyc(1'b0, kfips, 1'b0, 4'd0, 1'b0, 1'b0, 128'h0);
    status("mid-expand", 1'b1, 1'b0);
    #2 rstN = 1'b0;
    #1;
    status("async reset", 1'b0, 1'b0);
    chk("async reset rdKey", rdKey, 128'h0);
    chk("async reset rdValid", {127'h0, rdValid}, 128'h0);
    @(negedge clk);
    rstN = 1'b1;
    cyc(1'b0, kfips, 1'b1, 4'd0, 1'b0, 1'b1, 128'h0);

    // FIPS-197 schedule with reads while expanding
    cyc(1'b1, kfips, 1'b0, 4'd0, 1'b0, 1'b0, 128'h0);
    status("fips start", 1'b1, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      if (i == 3)      cyc(1'b0, 128'h0, 1'b1, 4'd5, 1'b0, 1'b0, 128'h0);
      else if (i == 4) cyc(1'b0, 128'h0, 1'b1, 4'd3, 1'b1, 1'b1, fips[3]);
      else if (i == 5) cyc(1'b0, 128'h0, 1'b1, 4'd5, 1'b0, 1'b0, 128'h0);
      else             cyc(1'b0, 128'h0, 1'b0, 4'd0, 1'b0, 1'b0, 128'h0);
      status($sformatf("fips edge+%0d", i), (i < 10), (i == 10));
    end
    for (int j = 0; j <= 12; j++)
      cyc(1'b0, 128'h0, 1'b1, tbl[j].idx, tbl[j].exp_v, tbl[j].chk_key, tbl[j].exp_k);

    // Starts during expansion are ignored
    cyc(1'b1, kfips, 1'b0, 4'd0, 1'b0, 1'b0, 128'h0);
    for (int i = 1; i <= 10; i++) begin
      if (i == 3) cyc(1'b1, 128'h0, 1'b1, 4'd2, 1'b1, 1'b1, fips[2]);
      else        cyc((i == 7), 128'h0, 1'b0, 4'd0, 1'b0, 1'b0, 128'h0);
      status($sformatf("ignore edge+%0d", i), (i < 10), (i == 10));
    end
    cyc(1'b0, 128'h0, 1'b1, 4'd1, 1'b1, 1'b1, fips[1]);
    cyc(1'b0, 128'h0, 1'b1, 4'd10, 1'b1, 1'b1, fips[10]);

    // Read port holds while rdEn=0, including across a restart with key 0
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 128'h0, 1'b0, 4'd0, 1'b0, 1'b0, 128'h0);
      chk("hold idle rdKey", rdKey, fips[10]);
      chk("hold idle rdValid", {127'h0, rdValid}, 128'h1);
    end
    cyc(1'b1, 128'h0, 1'b0, 4'd0, 1'b0, 1'b0, 128'h0);
    status("restart", 1'b1, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      if (i == 6) cyc(1'b0, 128'h0, 1'b1, 4'd8, 1'b0, 1'b0, 128'h0);
      else        cyc(1'b0, 128'h0, 1'b0, 4'd0, 1'b0, 1'b0, 128'h0);
      if (i < 6) begin
        chk("hold expand rdKey", rdKey, fips[10]);
        chk("hold expand rdValid", {127'h0, rdValid}, 128'h1);
      end
    end
    status("restart done", 1'b0, 1'b1);
    cyc(1'b0, 128'h0, 1'b1, 4'd10, 1'b1, 1'b1, zk10);
    cyc(1'b0, 128'h0, 1'b1, 4'd0, 1'b1, 1'b1, 128'h0);
    cyc(1'b0, 128'h0, 1'b1, 4'd1, 1'b1, 1'b1, zk1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/key_schedule_seq.md
Name: key_schedule_seq

Overview:
Sequential AES-128 key schedule. It sits directly upstream of the cipher round datapath. On a start pulse it captures the 128-bit cipher key and iterates the combinational keyExpansion stage once per clock to produce round keys 1..10. All 11 round keys are held in an internal register file and served through a registered read port addressed by round number. This lets the round engine fetch any key, forward or reverse (for decryption), without recomputing the schedule.

Parameters:
NROUNDS, 10, number of expansion rounds; the block stores NROUNDS+1 round keys (fixed at 10 for AES-128).
IDXW, 4, width of the round-index fields.

Ports:
clk  in  1  rising-edge clock
rstN  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin expansion of keyIn
keyIn  in  128  cipher key; sampled only on the accepted start cycle
busy  out  1  high while expansion is in progress
keyReady  out  1  high once all 11 round keys are valid; cleared by an accepted start
rdIdx  in  IDXW  round key index to read, 0..NROUNDS
rdEn  in  1  read request
rdKey  out  128  registered round key for rdIdx
rdValid  out  1  registered; high when rdKey holds a valid key for the requested index

Behaviour:
- Clock and reset: one clock (clk); reset (rstN) is asynchronous and active-low.
- Reset (rstN=0, asynchronous):
  - state=IDLE, busy=0, keyReady=0.
  - rdKey=128'h0, rdValid=0.
  - round counter=0, generated-count=0.
  - Register-file contents are don't-care but unreadable, because rdValid is gated by generated-count.
- States: IDLE, EXPAND.
- IDLE:
  - start=1 at edge E is accepted.
  - At E: store keyIn into slot 0, set generated-count=1, counter=1, busy=1, keyReady=0, enter EXPAND.
- EXPAND:
  - At each edge, slot[counter] <= keyExpansion(slot[counter-1], keyNum=counter). keyNum=1 selects rcon 0x01, continuing the AES sequence up to 0x36 at keyNum=10.
  - Each write increments generated-count and counter.
  - When counter==NROUNDS is written (edge E+10): busy=0, keyReady=1, return to IDLE.
  - Total latency from start edge to keyReady high is 10 cycles; keyReady is observed high in the cycle after edge E+10.
- Only one keyExpansion instance exists: one round key per cycle, no parallel expansion.
- start while busy=1: ignored, with no effect on the counter or stored keys.
- start in IDLE while keyReady=1: accepted. It clears keyReady at the same edge and overwrites slot 0, so the previous schedule is discarded.
- Read port (active in any state):
  - When rdEn=1 at an edge: rdKey <= slot[rdIdx].
  - rdValid <= (rdIdx < generated-count) && (rdIdx <= NROUNDS).
  - Latency is 1 cycle.
  - rdEn=0: rdKey and rdValid hold their previous values.
- Out-of-range or not-yet-generated index: rdKey <= 128'h0, rdValid <= 0.
- Read and write of the same slot at the same edge: the read returns the old content with rdValid=0. The slot is not yet counted in generated-count.
- Generated-count resets to 1 on each accepted start, so keys from the old schedule read as invalid (except slot 0, which is the new key).
- Byte and column ordering are identical to the codebase's bits2cols/cols2bits convention: col0 = keyIn[127:96].

Test Plan:
- Reset mid-EXPAND: start with any key, assert rstN=0 at cycle 5 -> busy=0, keyReady=0, rdKey=0, rdValid=0 immediately; a read of idx 0 after release gives rdValid=0.
- FIPS-197 vector: start with keyIn=2b7e151628aed2a6abf7158809cf4f3c -> busy high for 10 cycles, keyReady=1. Reads return:
  - idx1 = a0fafe1788542cb123a339392a6c7605
  - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6
  - idx0 = keyIn
  - all with rdValid=1 one cycle after rdEn.
- Read during expansion: rdIdx=5 asserted on the edge at which slot 3 is written -> rdValid=0. rdIdx=2 at the same edge -> correct key with rdValid=1.
- Out-of-range read: rdIdx=11 and rdIdx=15 with keyReady=1 -> rdKey=0, rdValid=0.
- start pulsed at cycles 3 and 7 of an expansion: ignored; round keys match the original vector. Restart in IDLE with keyIn=0 -> keyReady drops at the start edge; idx10 = b4ef5bcb3e92e21123e951cf6f8f188e after completion.
- rdEn=0 for several cycles after a read: rdKey and rdValid stay constant even while a new expansion runs.
